code_lock_ctrl: RTL and testbench
=================================

Name: code_lock_ctrl

Overview:
Parametrised successor to the four-button code detector. Detects a CODE_LEN-press sequence over N_BTN debounced push-buttons and checks the whole sequence before reporting, so a mismatch never shows early. Adds per-press progress display, inactivity timeout, failure counting with timed lockout, and a timed open window. Drives the board 7-segment digit directly.

Parameters:
N_BTN, 4, number of buttons; index 0=Top, 1=Down, 2=Left, 3=Right; range 2..16
CODE_LEN, 4, presses per code; range 1..9
CODE, 8'hE8, packed code, entry k at bits [k*BW +: BW], BW=$clog2(N_BTN); default Top,Left,Left,Right
MAX_FAIL, 3, consecutive failures that trigger lockout; range 1..15
TIMEOUT_CYCLES, 32, idle cycles in ENTRY before abort
SHOW_CYCLES, 16, cycles spent in OPEN and ERR
LOCK_CYCLES, 64, cycles spent in LOCKOUT

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn  in  N_BTN  raw asynchronous button levels, active-high
SSG_D  out  7  segments gfedcba, active-low
unlocked  out  1  high while in OPEN
locked_out  out  1  high while in LOCKOUT
fail_cnt  out  4  consecutive failures so far

Behaviour:
- Reset (reset=0): state IDLE, all counters 0, SSG_D=7'b1000000 ("0"), unlocked=0, locked_out=0, fail_cnt=0.
- Input path: 2-flop synchroniser per button, then rising-edge detect. A press event is the cycle where at least one synchronised bit rises; press-to-FSM latency is 3 cycles.
- Valid press: exactly one bit rises. Two or more rising bits in the same cycle form one invalid press, which sets mismatch.
- IDLE: the first press moves the FSM to ENTRY with pos=1 and mismatch=(sym!=CODE[0]).
- ENTRY: each press compares its symbol with CODE[pos], ORs the result into mismatch, and increments pos. When the press that makes pos==CODE_LEN arrives, the next state is OPEN if mismatch=0, else ERR.
- ENTRY timeout: timer clears on every press. At TIMEOUT_CYCLES idle cycles the FSM returns to IDLE; fail_cnt is unchanged.
- OPEN: unlocked=1 and fail_cnt clears to 0. After SHOW_CYCLES the FSM goes to IDLE.
- ERR: fail_cnt increments (saturating) on entry. After SHOW_CYCLES the FSM goes to LOCKOUT if fail_cnt==MAX_FAIL, else to IDLE.
- LOCKOUT: locked_out=1. After LOCK_CYCLES the FSM goes to IDLE and fail_cnt clears to 0.
- Presses are ignored in OPEN, ERR and LOCKOUT, except as listed under Optional Feature.
- Display:
  - IDLE: "0".
  - ENTRY: digit pos (1..9).
  - OPEN: "9" = 7'b0010000.
  - ERR: "E" = 7'b0000110.
  - LOCKOUT: "L" = 7'b1000111.
  - PROG: "P" = 7'b0001100.
- SSG_D is registered and updates 1 cycle after each state or pos change.
- Timers: one shared down-counter, sized for the largest cycle parameter, reloaded on every state entry.
- Reset asserted mid-operation returns everything to reset values immediately. The synchroniser clears too, so a button held through reset does not generate a press.

Optional Feature:
Macro CODE_PROG_EN.
- Defined: the code is held in a register loaded from CODE at reset. A Down press in OPEN enters PROG.
  - The next CODE_LEN valid presses are shifted in as the new code; it commits on the last press, then the FSM goes to IDLE.
  - An invalid press or a TIMEOUT_CYCLES idle period aborts to IDLE with the old code kept.
- Undefined: the code is the constant CODE, the PROG state does not exist, and a Down press in OPEN is ignored.

Decomposition:
- Package code_lock_pkg holds:
  - state enum: IDLE, ENTRY, OPEN, ERR, LOCKOUT, PROG;
  - 7-segment glyph constants for 0-9, E, L and P;
  - button index constants.
- Sub-module ssg_glyph_dec: a 4-bit glyph select in, 7-bit active-low segments out. It is combinational; the parent registers the result.

Test Plan:
- Reset, then Top,Left,Left,Right with gaps of ≥4 cycles → SSG_D steps 1,2,3,4; then "9"; unlocked=1 for 16 cycles; then "0".
- Top,Down,Left,Right → no early reject; SSG_D shows 4, then "E"; fail_cnt=1; IDLE after 16 cycles.
- Three wrong codes in a row → third ERR is followed by LOCKOUT: locked_out=1 and "L" for 64 cycles, with presses ignored. Afterwards fail_cnt=0.
- Top, then 32 idle cycles → IDLE, "0", fail_cnt unchanged. Separately, Top and Left rising in the same cycle followed by 3 valid presses → ERR.
- Two wrong codes then the correct code → OPEN and fail_cnt=0. Reset pulsed low mid-ENTRY → all outputs return to reset values.
- CODE_PROG_EN: open the lock, press Down, enter Right,Right,Top,Top → the new code opens the lock and the old code gives ERR.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared types and constants for the code lock controller.
// Optional macro CODE_PROG_EN enables the reprogrammable code (PROG state).
package code_lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        OPEN,
        ERR,
        LOCKOUT,
        PROG
    } state_e;

    // Active-low gfedcba glyphs
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Glyph selects beyond the decimal digits
    localparam logic [3:0] GSEL_E = 4'd10;
    localparam logic [3:0] GSEL_L = 4'd11;
    localparam logic [3:0] GSEL_P = 4'd12;

    // Button indices
    localparam int unsigned BTN_TOP   = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/code_lock_ctrl_ssg_glyph_dec.sv
// Combinational glyph-select to active-low 7-segment decoder.
module ssg_glyph_dec
    import code_lock_pkg::*;
(
    input  logic [3:0] sel,
    output logic [6:0] seg_c
);

    // Map select code to segment pattern; unused codes blank the digit
    always_comb begin
        seg_c = SEG_BLANK;
        case (sel)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            GSEL_E:  seg_c = SEG_E;
            GSEL_L:  seg_c = SEG_L;
            GSEL_P:  seg_c = SEG_P;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/code_lock_ctrl.sv
// Button code lock: full-sequence check, timeout, failure lockout, 7-seg status.
// Optional macro CODE_PROG_EN: code held in a register, reprogrammable from OPEN.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int unsigned N_BTN          = 4,
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [CODE_LEN*$clog2(N_BTN)-1:0] CODE = 8'hE8,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter int unsigned SHOW_CYCLES    = 16,
    parameter int unsigned LOCK_CYCLES    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic [6:0]       SSG_D,
    output logic             unlocked,
    output logic             locked_out,
    output logic [3:0]       fail_cnt
);

    localparam int unsigned BW    = $clog2(N_BTN);
    localparam int unsigned CW    = CODE_LEN * BW;
    localparam int unsigned T_MAX = max3(TIMEOUT_CYCLES, SHOW_CYCLES, LOCK_CYCLES);
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    localparam logic [3:0]    LEN_P     = 4'(CODE_LEN);
    localparam logic [3:0]    LAST_P    = 4'(CODE_LEN - 1);
    localparam logic [3:0]    MAXF_P    = 4'(MAX_FAIL);
    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_SHOW    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK    = TW'(LOCK_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q, sync2_q, prev_q, rise_c;
    logic             press_c, valid_c;
    logic [BW-1:0]    sym_c, exp_sym_c;
    logic [CW-1:0]    code_c;
    logic [3:0]       gsel_c;
    logic [6:0]       seg_c;

    state_e        state_q, state_d;
    logic [3:0]    pos_q, pos_d;
    logic          mism_q, mism_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    fail_q, fail_d;
    logic [6:0]    ssg_q, ssg_d;
    logic          unlocked_q, unlocked_d;
    logic          locked_q, locked_d;
    logic          tick_c;

`ifdef CODE_PROG_EN
    logic [CW-1:0] code_q, code_d, prog_q, prog_d;
    assign code_c = code_q;
`else
    assign code_c = CODE;
`endif

    // Synchroniser and edge history; reset to "all held" so a button held through reset never looks like a fresh press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_c    = sync2_q & ~prev_q;
    assign exp_sym_c = code_c[int'(pos_q) * int'(BW) +: BW];

    // Press event classification and symbol encoding
    always_comb begin
        sym_c = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (rise_c[i]) sym_c = BW'(i);
        end
        press_c = |rise_c;
        valid_c = $onehot(rise_c);
    end

    // Next-state, counters and registered-output inputs
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        mism_d  = mism_q;
        fail_d  = fail_q;
        timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        tick_c  = (timer_q == '0);
`ifdef CODE_PROG_EN
        code_d  = code_q;
        prog_d  = prog_q;
`endif
        case (state_q)
            IDLE: begin
                if (press_c) begin
                    state_d = ENTRY;
                    pos_d   = 4'd1;
                    mism_d  = !valid_c || (sym_c != exp_sym_c);
                    timer_d = T_TIMEOUT;
                end
            end
            ENTRY: begin
                if (pos_q == LEN_P) begin
                    timer_d = T_SHOW;
                    if (mism_q) begin
                        state_d = ERR;
                        if (fail_q != 4'hF) fail_d = fail_q + 4'd1;
                    end else begin
                        state_d = OPEN;
                        fail_d  = '0;
                    end
                end else if (press_c) begin
                    pos_d   = pos_q + 4'd1;
                    mism_d  = mism_q || !valid_c || (sym_c != exp_sym_c);
                    timer_d = T_TIMEOUT;
                end else if (tick_c) begin
                    state_d = IDLE;
                end
            end
            OPEN: begin
`ifdef CODE_PROG_EN
                if (valid_c && (sym_c == BW'(BTN_DOWN))) begin
                    state_d = PROG;
                    pos_d   = '0;
                    timer_d = T_TIMEOUT;
                end else
`endif
                if (tick_c) state_d = IDLE;
            end
            ERR: begin
                if (tick_c) begin
                    if (fail_q == MAXF_P) begin
                        state_d = LOCKOUT;
                        timer_d = T_LOCK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                if (tick_c) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            PROG: begin
`ifdef CODE_PROG_EN
                if (press_c) begin
                    if (!valid_c) begin
                        state_d = IDLE;
                    end else begin
                        prog_d[int'(pos_q) * int'(BW) +: BW] = sym_c;
                        if (pos_q == LAST_P) begin
                            code_d  = prog_d;
                            state_d = IDLE;
                        end else begin
                            pos_d   = pos_q + 4'd1;
                            timer_d = T_TIMEOUT;
                        end
                    end
                end else if (tick_c) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            pos_d  = '0;
            mism_d = 1'b0;
        end

        unlocked_d = (state_d == OPEN);
        locked_d   = (state_d == LOCKOUT);
        ssg_d      = seg_c;
    end

    // Glyph selection from the current state and entry position
    always_comb begin
        gsel_c = 4'd0;
        case (state_q)
            ENTRY:   gsel_c = pos_q;
            OPEN:    gsel_c = 4'd9;
            ERR:     gsel_c = GSEL_E;
            LOCKOUT: gsel_c = GSEL_L;
            PROG:    gsel_c = GSEL_P;
            default: gsel_c = 4'd0;
        endcase
    end

    ssg_glyph_dec u_glyph (
        .sel   (gsel_c),
        .seg_c (seg_c)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            mism_q     <= 1'b0;
            timer_q    <= '0;
            fail_q     <= '0;
            ssg_q      <= SEG_0;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
`ifdef CODE_PROG_EN
            code_q     <= CODE;
            prog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            mism_q     <= mism_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            ssg_q      <= ssg_d;
            unlocked_q <= unlocked_d;
            locked_q   <= locked_d;
`ifdef CODE_PROG_EN
            code_q     <= code_d;
            prog_q     <= prog_d;
`endif
        end
    end

    assign SSG_D      = ssg_q;
    assign unlocked   = unlocked_q;
    assign locked_out = locked_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl with a sequence-level reference model.
module tb_code_lock_ctrl;

    localparam int MAX_FAIL = 3;
    localparam int TIMEOUT  = 32;
    localparam int SHOW     = 16;
    localparam int LOCK     = 64;

    localparam logic [6:0] G_0 = 7'h40;
    localparam logic [6:0] G_9 = 7'h10;
    localparam logic [6:0] G_E = 7'h06;
    localparam logic [6:0] G_L = 7'h47;
    localparam logic [6:0] G_P = 7'h0C;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [6:0] ssg;
    logic       unlocked, locked_out;
    logic [3:0] fail_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int fail_m      = 0;
    int code_m [4]  = '{0, 2, 2, 3};
    logic [6:0] digit_g [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Run-length history of the display and status outputs
    logic [6:0] run_val [$];
    int         run_len [$];
    logic [6:0] cur_val = 7'h40;
    int         cur_len = 0;
    int         u_run = 0, u_last = 0, l_run = 0, l_last = 0;

    always #5 clk = ~clk;

    code_lock_ctrl #(
        .N_BTN(4), .CODE_LEN(4), .CODE(8'hE8), .MAX_FAIL(MAX_FAIL),
        .TIMEOUT_CYCLES(TIMEOUT), .SHOW_CYCLES(SHOW), .LOCK_CYCLES(LOCK)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .SSG_D(ssg),
        .unlocked(unlocked), .locked_out(locked_out), .fail_cnt(fail_cnt)
    );

    always @(negedge clk) begin
        if (ssg === cur_val) cur_len++;
        else begin
            run_val.push_back(cur_val);
            run_len.push_back(cur_len);
            cur_val = ssg;
            cur_len = 1;
        end
        if (unlocked === 1'b1) u_run++;
        else if (u_run != 0) begin u_last = u_run; u_run = 0; end
        if (locked_out === 1'b1) l_run++;
        else if (l_run != 0) begin l_last = l_run; l_run = 0; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find_run(input logic [6:0] v);
        for (int i = run_val.size() - 1; i >= 0; i--)
            if (run_val[i] === v) return run_len[i];
        return -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_runs();
        @(posedge clk);
        run_val.delete();
        run_len.delete();
    endtask

    // One press: raise mask after a posedge, release two cycles later, sample after the display updates
    task automatic press(input logic [3:0] m);
        @(posedge clk); #1 btn = m;
        repeat (2) @(posedge clk);
        #1 btn = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ssg === G_0 && unlocked === 1'b0 && locked_out === 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < 300), 1);
        @(negedge clk); #1;
    endtask

    // Full code attempt checked against the sequence-level model
    task automatic enter_code(input logic [3:0] m [4]);
        bit ok, lock_exp;
        ok = 1'b1;
        lock_exp = 1'b0;
        for (int k = 0; k < 4; k++)
            if (m[k] !== 4'(1 << code_m[k])) ok = 1'b0;
        clear_runs();
        for (int k = 0; k < 4; k++) begin
            press(m[k]);
            check("entry_digit", ssg, digit_g[k+1]);
            if (k < 3) idle($urandom_range(0, 5));
        end
        @(negedge clk);
        if (ok) begin
            fail_m = 0;
            check("open_glyph", ssg, G_9);
            check("open_unlocked", unlocked, 1);
            check("open_fail_cnt", fail_cnt, fail_m);
        end else begin
            fail_m = (fail_m < 15) ? fail_m + 1 : 15;
            lock_exp = (fail_m == MAX_FAIL);
            check("err_glyph", ssg, G_E);
            check("err_unlocked", unlocked, 0);
            check("err_fail_cnt", fail_cnt, fail_m);
        end
        if (lock_exp) begin
            idle(20);
            check("lock_glyph", ssg, G_L);
            check("lock_flag", locked_out, 1);
            press(4'b0001);
            press(4'b0100);
            check("lock_ignores_press", ssg, G_L);
        end
        wait_idle();
        check("last_digit_run", find_run(digit_g[4]), 1);
        if (ok) begin
            check("open_glyph_run", find_run(G_9), SHOW);
            check("unlocked_run", u_last, SHOW);
        end else begin
            check("err_glyph_run", find_run(G_E), SHOW);
        end
        if (lock_exp) begin
            check("lock_glyph_run", find_run(G_L), LOCK);
            check("locked_run", l_last, LOCK);
            fail_m = 0;
            check("lock_fail_clear", fail_cnt, 0);
        end
    endtask

    logic [3:0] seq [4];
    logic [3:0] good [4];
    int s, j;

    initial begin
        btn   = '0;
        reset = 1'b0;
        good  = '{4'b0001, 4'b0100, 4'b0100, 4'b1000};
        idle(3);
        check("rst_ssg", ssg, G_0);
        check("rst_unlocked", unlocked, 0);
        check("rst_locked", locked_out, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        @(negedge clk) reset = 1'b1;
        idle(4);

        enter_code(good);
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        enter_code(seq);

        // Single press then inactivity
        clear_runs();
        press(4'b0001);
        check("to_digit", ssg, digit_g[1]);
        idle(27);
        check("to_still_entry", ssg, digit_g[1]);
        wait_idle();
        check("to_entry_run", find_run(digit_g[1]), TIMEOUT);
        check("to_fail_kept", fail_cnt, fail_m);

        // Simultaneous Top+Left counts as one wrong press
        seq = '{4'b0101, 4'b0100, 4'b0100, 4'b1000};
        enter_code(seq);
        seq = '{4'b1000, 4'b1000, 4'b0100, 4'b0100};
        enter_code(seq);

        seq = '{4'b0010, 4'b0100, 4'b0100, 4'b1000};
        enter_code(seq);
        seq = '{4'b0001, 4'b0100, 4'b0100, 4'b0100};
        enter_code(seq);
        enter_code(good);

        // Reset mid-entry with a button held through it
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
        enter_code(seq);
        press(4'b0001);
        press(4'b0100);
        @(negedge clk);
        btn   = 4'b1000;
        reset = 1'b0;
        #1;
        check("mid_rst_ssg", ssg, G_0);
        check("mid_rst_unlocked", unlocked, 0);
        check("mid_rst_locked", locked_out, 0);
        check("mid_rst_fail_cnt", fail_cnt, 0);
        fail_m = 0;
        idle(3);
        @(negedge clk) reset = 1'b1;
        idle(8);
        check("held_btn_no_press", ssg, G_0);
        btn = '0;
        idle(4);
        check("release_no_press", ssg, G_0);

`ifdef CODE_PROG_EN
        clear_runs();
        for (int k = 0; k < 4; k++) press(good[k]);
        @(negedge clk);
        check("prog_open", ssg, G_9);
        press(4'b0010);
        check("prog_glyph", ssg, G_P);
        seq = '{4'b1000, 4'b1000, 4'b0001, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            press(seq[k]);
            if (k < 3) check("prog_entry", ssg, G_P);
        end
        check("prog_commit_idle", ssg, G_0);
        code_m = '{3, 3, 0, 0};
        fail_m = 0;
        wait_idle();
        enter_code(seq);
        enter_code(good);
`endif

        // Randomised attempts: correct code, random one-hot symbols, or one multi-bit press
        for (int t = 0; t < 10; t++) begin
            s = int'($urandom_range(0, 2));
            for (int k = 0; k < 4; k++) begin
                if (s == 0) seq[k] = 4'(1 << code_m[k]);
                else        seq[k] = 4'(1 << $urandom_range(0, 3));
            end
            if (s == 2) begin
                j = int'($urandom_range(0, 3));
                seq[j] = seq[j] | {seq[j][2:0], seq[j][3]};
            end
            enter_code(seq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
